// File: rtl/alu_muldiv_rv32m.sv
// ---------------------------------------------------------------------------
// alu_muldiv_rv32m
// Iterative RV32M multiply/divide unit for the execute stage. One iteration
// per cycle: shift-add multiply over absolute/unsigned operands with a
// 2*XLEN-bit product, and restoring division over absolute values. Signs
// and RISC-V special cases are resolved in the cycle that enters DONE.
//
// Optional feature macro: MULDIV_FASTPATH_EN
//   When defined, divide-by-zero, signed division overflow and multiply by
//   zero go IDLE->DONE directly (out_valid high one edge after acceptance).
//
// Ports:
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operands/opcode valid          in_ready   unit can accept
//   in1, in2   rs1 / rs2 operands             cu_mdtype  RV32M funct3
//   flush      abort operation in flight
//   out_valid  result valid                   out_ready  consumer accepts
//   out        result                         busy       not IDLE
// ---------------------------------------------------------------------------
module alu_muldiv_rv32m #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      cu_mdtype,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Special-case detection: {hit, value}. op[2]=divide, op[1]=remainder,
    // op[0]=unsigned (divide group only).
    function automatic logic [XLEN:0] f_special(input logic [2:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN-1:0] v_min;
        logic [XLEN:0]   v_res;
        v_min = {1'b1, {(XLEN-1){1'b0}}};
        v_res = {1'b0, {XLEN{1'b0}}};
        if (op[2]) begin
            if (b == {XLEN{1'b0}}) begin
                v_res = {1'b1, (op[1] ? a : {XLEN{1'b1}})};
            end else if (!op[0] && (a == v_min) && (b == {XLEN{1'b1}})) begin
                v_res = {1'b1, (op[1] ? {XLEN{1'b0}} : a)};
            end else begin
                v_res = {1'b0, {XLEN{1'b0}}};
            end
        end else begin
            if ((a == {XLEN{1'b0}}) || (b == {XLEN{1'b0}})) begin
                v_res = {1'b1, {XLEN{1'b0}}};
            end else begin
                v_res = {1'b0, {XLEN{1'b0}}};
            end
        end
        return v_res;
    endfunction

    state_t            r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_in1;
    logic [XLEN-1:0]   r_in2;
    logic [XLEN-1:0]   r_opa;      // multiplicand or divisor (absolute)
    logic [2*XLEN-1:0] r_acc;      // {hi, multiplier} or {remainder, quotient}
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_x;    // product / quotient negative
    logic              r_neg_a;    // remainder negative
    logic [XLEN-1:0]   r_out;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_in_ready;

    logic              w_a_signed, w_b_signed, w_neg1, w_neg2;
    logic [XLEN-1:0]   w_abs1, w_abs2;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_val;
    logic [XLEN:0]     w_mul_sum, w_div_trial;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_result;
    logic [XLEN:0]     w_spec;

    // Operand signedness and absolute values at acceptance
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (cu_mdtype)
            OP_MULH:        begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            OP_MULHSU:      begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            OP_DIV, OP_REM: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
        w_neg1 = w_a_signed & in1[XLEN-1];
        w_neg2 = w_b_signed & in2[XLEN-1];
        w_abs1 = w_neg1 ? ({XLEN{1'b0}} - in1) : in1;
        w_abs2 = w_neg2 ? ({XLEN{1'b0}} - in2) : in2;
`ifdef MULDIV_FASTPATH_EN
        {w_fast, w_fast_val} = f_special(cu_mdtype, in1, in2);
`else
        w_fast     = 1'b0;
        w_fast_val = {XLEN{1'b0}};
`endif
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                   + (r_acc[0] ? {1'b0, r_opa} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        // Shifted partial remainder (with next dividend bit) minus divisor;
        // bit XLEN set means the trial went negative and is discarded.
        w_div_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opa};
        if (!w_div_trial[XLEN]) begin
            w_div_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_div_next = {r_acc[2*XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and special-case override for the final result
    always_comb begin
        w_prod = r_neg_x ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
        w_quo  = r_neg_x ? ({XLEN{1'b0}} - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_rem  = r_neg_a ? ({XLEN{1'b0}} - r_acc[2*XLEN-1:XLEN])
                         : r_acc[2*XLEN-1:XLEN];
        w_spec = f_special(r_op, r_in1, r_in2);
        if (w_spec[XLEN]) begin
            w_result = w_spec[XLEN-1:0];
        end else begin
            case (r_op)
                OP_MUL:                       w_result = w_prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              w_result = w_quo;
                default:                      w_result = w_rem;
            endcase
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_in1       <= {XLEN{1'b0}};
            r_in2       <= {XLEN{1'b0}};
            r_opa       <= {XLEN{1'b0}};
            r_acc       <= {(2*XLEN){1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_neg_x     <= 1'b0;
            r_neg_a     <= 1'b0;
            r_out       <= {XLEN{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        r_op       <= cu_mdtype;
                        r_in1      <= in1;
                        r_in2      <= in2;
                        r_neg_x    <= w_neg1 ^ w_neg2;
                        r_neg_a    <= w_neg1;
                        r_opa      <= cu_mdtype[2] ? w_abs2 : w_abs1;
                        r_acc      <= {{XLEN{1'b0}}, (cu_mdtype[2] ? w_abs1 : w_abs2)};
                        r_cnt      <= {CNT_W{1'b0}};
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        if (w_fast) begin
                            // out_valid follows one edge later from DONE
                            r_out   <= w_fast_val;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_cnt       <= {CNT_W{1'b0}};
                    end else if (r_cnt == CNT_LAST) begin
                        r_out       <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    if (flush || (r_out_valid && out_ready)) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_cnt       <= {CNT_W{1'b0}};
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign busy      = r_busy;

endmodule

// File: doc/alu_muldiv_rv32m.md
Name: alu_muldiv_rv32m

Overview:
- Iterative multiply/divide unit implementing the RV32M operations, parametrised in operand width.
- Sits beside the combinational RV32I ALU in the execute stage.
- Operands use the same in1/in2 convention as the RV32I ALU (in1 = rs1, in2 = rs2).
- Uses a valid/ready handshake, because results take multiple cycles; the pipeline stalls on busy.

Parameters:
- XLEN, 32: operand and result width. Legal values are 8, 16, 32 and 64.
- CNT_W, $clog2(XLEN)+1: width of the internal iteration counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  unit can accept an operation.
- in1  input  XLEN  rs1 operand (multiplicand or dividend).
- in2  input  XLEN  rs2 operand (multiplier or divisor).
- cu_mdtype  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- flush  input  1  synchronous abort of the operation in flight.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out  output  XLEN  result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: when reset_n=0 at a rising clock edge, the unit enters IDLE.
  - Output values in reset: out_valid=0, out=0, busy=0, internal counter=0.
  - in_ready is 1 once in IDLE.
  - Reset overrides flush and any handshake, including mid-operation.
- States:
  - IDLE: in_ready=1, busy=0. in_valid=1 captures in1, in2 and cu_mdtype, then goes to CALC (or to DONE via fast path, see Optional Feature).
  - CALC: in_ready=0, busy=1. Performs one iteration per cycle for exactly XLEN cycles, then goes to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0. out_valid=1 together with out_ready=1 returns the unit to IDLE. out and out_valid are held stable while out_ready=0.
- Latency: with acceptance at edge 0, out_valid is first high after edge XLEN+1. A new operation can be accepted in the cycle after the DONE→IDLE transition.
- Multiply:
  - Shift-add over absolute or unsigned operands, with a 2*XLEN-bit product.
  - MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
  - Signedness: MULH treats both operands as signed. MULHSU treats in1 as signed and in2 as unsigned. MULHU treats both as unsigned.
  - Sign correction is applied after the last iteration, inside the DONE transition cycle.
- Divide:
  - Restoring division over absolute values.
  - Quotient sign = sign(in1) XOR sign(in2). Remainder sign = sign(in1).
- Special cases must match the RISC-V spec in all build configurations:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return in1.
  - Signed overflow (in1 = most negative, in2 = -1): DIV returns in1; REM returns 0.
- flush=1 in CALC or DONE: the next state is IDLE and out_valid drops at the next edge; the result is discarded. flush in IDLE has no effect, and any in_valid presented in the same cycle is ignored.
- in_valid while busy is ignored and is not queued.
- cu_mdtype is only sampled at acceptance; changes to it mid-operation have no effect.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- When defined, these cases skip CALC and go IDLE→DONE, with out_valid high after edge 1:
  - divide by zero;
  - signed division overflow;
  - multiply where either operand is 0.
- When undefined, every operation takes the full XLEN+1 latency with identical result values.

Test Plan:
- XLEN=32, MUL, in1=7, in2=-3 (0xFFFFFFFD) -> out=0xFFFFFFEB; out_valid first high after edge 33; MULHU with the same operands -> out=0x00000006.
- DIV, in1=-20, in2=3 -> out=0xFFFFFFFA (-6); REM with the same operands -> out=0xFFFFFFFE (-2); DIVU 100/7 -> 14.
- DIVU, in1=0x12345678, in2=0 -> out=0xFFFFFFFF; REMU -> out=0x12345678; DIV 0x80000000/-1 -> 0x80000000. With MULDIV_FASTPATH_EN, out_valid is high after edge 1.
- Hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0, and a second in_valid is ignored. Then out_ready=1 -> IDLE, in_ready=1.
- flush at CALC cycle 10 -> IDLE next edge, out_valid never asserts. A follow-up MULH 0x80000000*0x80000000 -> out=0x40000000.
- reset_n=0 mid-CALC -> next edge busy=0, out_valid=0, out=0, in_ready=1. A new op issued after release completes correctly.
